// File: rtl/nco_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel NCO clock generator.
package nco_clk_gen_pkg;

  localparam int unsigned CH_IDX_W = 3;

  typedef enum logic [1:0] {
    INIT,
    SETTLE,
    LOCKED
  } state_e;

  // Phase increment for out_hz from ref_hz: out_hz * 2^acc_w / ref_hz, truncated.
  function automatic logic [63:0] freq_to_inc(input logic [63:0] ref_hz,
                                              input logic [63:0] out_hz,
                                              input int unsigned acc_w);
    logic [127:0] num;
    num = 128'(out_hz) << acc_w;
    return 64'(num / 128'(ref_hz));
  endfunction

endpackage

// File: rtl/nco_acc.sv
// One NCO channel: phase accumulator, increment register, registered wrap pulse and MSB.
module nco_acc
  import nco_clk_gen_pkg::*;
#(
  parameter int unsigned      ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic [ACC_W-1:0] phase_i,
  input  logic             gate_i,
  output logic             tick_o,
  output logic             msb_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             carry_d;
  logic             tick_q, msb_q;

  // A load takes priority over accumulation and never produces a wrap pulse.
  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    carry_d = 1'b0;
    if (load_i) begin
      acc_d = phase_i;
      inc_d = inc_i;
    end else if (en_i) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      inc_q  <= INC_RST;
      tick_q <= 1'b0;
      msb_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      tick_q <= carry_d & gate_i;
      msb_q  <= acc_d[ACC_W-1] & gate_i;
    end
  end

  assign tick_o = tick_q;
  assign msb_o  = msb_q;

endmodule

// File: rtl/nco_clk_gen.sv
// Multi-channel NCO clock-enable generator with settle/lock FSM and runtime config port.
// Optional per-channel emitted-tick counters when NCO_CLK_GEN_TICK_CNT_EN is defined.
module nco_clk_gen
  import nco_clk_gen_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 2,
  parameter int unsigned      ACC_W       = 32,
  parameter int unsigned      LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] INC_RST     = ACC_W'(32'h3D70A3D7)
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic [NUM_CH-1:0]   tick_out,
  output logic [NUM_CH-1:0]   clk_out,
  output logic                locked,
  output logic                cfg_err
`ifdef NCO_CLK_GEN_TICK_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] tick_cnt
`endif
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              locked_q, cfg_ready_q, cfg_err_q;
  logic              xfer_c, ch_ok_c, lock_d_c;
  logic [NUM_CH-1:0] load_c;

  // Transfer decode; lock_d_c is next-cycle lock so outputs gate in step with locked.
  always_comb begin
    xfer_c   = cfg_valid & cfg_ready_q;
    ch_ok_c  = 32'(cfg_ch) < NUM_CH;
    lock_d_c = ~xfer_c & ((state_q == LOCKED) |
                          ((state_q == SETTLE) & (cnt_q == CNT_LAST)));
    load_c   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (xfer_c && ch_ok_c && (cfg_ch == CH_IDX_W'(c))) load_c[c] = 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b1;
      locked_q    <= lock_d_c;
      if (xfer_c && !ch_ok_c) cfg_err_q <= 1'b1;
      unique case (state_q)
        INIT: begin
          state_q <= SETTLE;
          cnt_q   <= '0;
        end
        SETTLE: begin
          if (xfer_c)                 cnt_q   <= '0;
          else if (cnt_q == CNT_LAST) state_q <= LOCKED;
          else                        cnt_q   <= cnt_q + CNT_W'(1);
        end
        LOCKED: begin
          if (xfer_c) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    nco_acc #(
      .ACC_W  (ACC_W),
      .INC_RST(INC_RST)
    ) u_acc (
      .clk    (refclk),
      .rst    (rst),
      .en_i   (ch_en[c]),
      .load_i (load_c[c]),
      .inc_i  (cfg_inc),
      .phase_i(cfg_phase),
      .gate_i (lock_d_c),
      .tick_o (tick_out[c]),
      .msb_o  (clk_out[c])
    );

`ifdef NCO_CLK_GEN_TICK_CNT_EN
    logic [15:0] tcnt_q;
    always_ff @(posedge refclk or posedge rst) begin
      if (rst)            tcnt_q <= '0;
      else if (load_c[c]) tcnt_q <= '0;
      else                tcnt_q <= tcnt_q + 16'(tick_out[c]);
    end
    assign tick_cnt[c*16 +: 16] = tcnt_q;
`endif
  end

  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_nco_clk_gen.sv
// Self-checking bench for nco_clk_gen: phase-arithmetic reference model plus directed scenarios.
module tb_nco_clk_gen;
  import nco_clk_gen_pkg::*;

  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam logic [63:0] INC_DEF     = 64'h3D70A3D7;
  localparam logic [63:0] MOD         = 64'd1 << ACC_W;

  logic                refclk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   ch_en;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [ACC_W-1:0]    cfg_inc;
  logic [ACC_W-1:0]    cfg_phase;
  logic [NUM_CH-1:0]   tick_out;
  logic [NUM_CH-1:0]   clk_out;
  logic                locked;
  logic                cfg_err;
`ifdef NCO_CLK_GEN_TICK_CNT_EN
  logic [NUM_CH*16-1:0] tick_cnt;
`endif

  nco_clk_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .ch_en    (ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .tick_out (tick_out),
    .clk_out  (clk_out),
    .locked   (locked),
    .cfg_err  (cfg_err)
`ifdef NCO_CLK_GEN_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase as plain integers, lock as a countdown of remaining edges.
  logic [63:0] m_acc [NUM_CH];
  logic [63:0] m_inc [NUM_CH];
  logic [15:0] m_tcnt[NUM_CH];
  logic        e_tick[NUM_CH];
  logic        e_clk [NUM_CH];
  logic        m_rdy, m_locked, m_err;
  int          m_remain;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c] = 0; m_inc[c] = INC_DEF; m_tcnt[c] = 0;
      e_tick[c] = 1'b0; e_clk[c] = 1'b0;
    end
    m_rdy = 1'b0; m_locked = 1'b0; m_err = 1'b0;
    m_remain = LOCK_CYCLES + 1;
  endtask

  initial begin : model
    logic        xfer;
    logic        carry[NUM_CH];
    logic [63:0] s;
    model_reset();
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        xfer = cfg_valid && m_rdy;
        m_rdy = 1'b1;
        if (xfer) begin
          if (int'(cfg_ch) >= NUM_CH) m_err = 1'b1;
          m_remain = LOCK_CYCLES;
          m_locked = 1'b0;
        end else if (m_remain > 0) begin
          m_remain--;
          m_locked = (m_remain == 0);
        end
        for (int c = 0; c < NUM_CH; c++) begin
          carry[c] = 1'b0;
          if (xfer && int'(cfg_ch) == c) begin
            m_acc[c] = 64'(cfg_phase);
            m_inc[c] = 64'(cfg_inc);
            m_tcnt[c] = 0;
          end else begin
            m_tcnt[c] = m_tcnt[c] + 16'(e_tick[c]);
            if (ch_en[c]) begin
              s = m_acc[c] + m_inc[c];
              carry[c] = (s >= MOD);
              m_acc[c] = s % MOD;
            end
          end
          e_tick[c] = carry[c] && m_locked;
          e_clk[c]  = m_locked && m_acc[c][ACC_W-1];
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge refclk);
      chk("locked", 64'(locked), 64'(m_locked));
      chk("cfg_ready", 64'(cfg_ready), 64'(m_rdy));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("tick_out[%0d]", c), 64'(tick_out[c]), 64'(e_tick[c]));
        chk($sformatf("clk_out[%0d]", c), 64'(clk_out[c]), 64'(e_clk[c]));
`ifdef NCO_CLK_GEN_TICK_CNT_EN
        chk($sformatf("tick_cnt[%0d]", c), 64'(tick_cnt[c*16 +: 16]), 64'(m_tcnt[c]));
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  // Cycles until locked (bounded), plus ticks seen on any channel meanwhile.
  task automatic wait_lock(input int limit, output int n, output int tk);
    n = 0; tk = 0;
    while (!locked && n < limit) begin
      step(1);
      n++;
      tk += int'(tick_out[0]) + int'(tick_out[1]);
    end
  endtask

  task automatic do_cfg(input int ch, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph);
    int k = 0;
    cfg_valid = 1'b1; cfg_ch = CH_IDX_W'(ch); cfg_inc = inc; cfg_phase = ph;
    while (!cfg_ready && k < 20) begin step(1); k++; end
    step(1);
    cfg_valid = 1'b0;
  endtask

  // Tick count, tick spacing and clk_out half-period behaviour of ch0 over n cycles.
  task automatic measure0(input int n, output int ticks, output int bad_gap,
                          output int highs, output int bad_half);
    logic h[$];
    int   last = -1;
    ticks = 0; bad_gap = 0; highs = 0; bad_half = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      h.push_back(clk_out[0]);
      highs += int'(clk_out[0]);
      if (tick_out[0]) begin
        ticks++;
        if (last >= 0 && i - last != 4) bad_gap++;
        last = i;
      end
      if (i >= 2 && h[i] == h[i-2]) bad_half++;
    end
  endtask

  initial begin : stim
    int n, tk, ticks, gap, highs, half, wide, chg;
    logic prev, snap;
    rst = 1'b1; ch_en = 2'b11; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;

    chk("freq_to_inc_12M", freq_to_inc(64'd50_000_000, 64'd12_000_000, 32), 64'h3D70A3D7);
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_tick", 64'(tick_out), 64'd0);
    chk("rst_clk", 64'(clk_out), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    #1 rst = 1'b0;

    wait_lock(40, n, tk);
    chk("lock_latency", 64'(n), 64'd17);
    ticks = 0; wide = 0; prev = 1'b0;
    repeat (100) begin
      step(1);
      ticks += int'(tick_out[0]);
      if (tick_out[0] && prev) wide++;
      prev = tick_out[0];
    end
    chk("tick_rate_12M", 64'(ticks >= 23 && ticks <= 24), 64'd1);
    chk("tick_width", 64'(wide), 64'd0);

    chk("ready_when_locked", 64'(cfg_ready), 64'd1);
    do_cfg(0, 32'h4000_0000, 32'h0);
    chk("lock_drop", 64'(locked), 64'd0);
    wait_lock(40, n, tk);
    chk("relock_latency", 64'(n), 64'd16);
    measure0(16, ticks, gap, highs, half);
    chk("q_ticks", 64'(ticks), 64'd4);
    chk("q_gap", 64'(gap), 64'd0);
    chk("q_highs", 64'(highs), 64'd8);
    chk("q_half", 64'(half), 64'd0);

    do_cfg(5, 32'h1234_5678, 32'h0000_ABCD);
    chk("err_set", 64'(cfg_err), 64'd1);
    wait_lock(40, n, tk);
    chk("bad_ch_relock", 64'(n), 64'd16);
    measure0(16, ticks, gap, highs, half);
    chk("bad_ch_inc_kept", 64'(ticks == 4 && gap == 0), 64'd1);
    chk("err_sticky", 64'(cfg_err), 64'd1);

    do_cfg(0, 32'h8000_0000, 32'h0);
    wait_lock(40, n, tk);
    step(2);
    ch_en = 2'b10;
    snap = clk_out[0]; tk = 0; chg = 0;
    repeat (5) begin
      step(1);
      tk += int'(tick_out[0]);
      chg += int'(clk_out[0] != snap);
    end
    chk("dis_no_tick", 64'(tk), 64'd0);
    chk("dis_clk_hold", 64'(chg), 64'd0);
    ch_en = 2'b11;
    chg = 0; prev = clk_out[0];
    repeat (4) begin
      step(1);
      chg += int'(clk_out[0] != prev);
      prev = clk_out[0];
    end
    chk("reen_toggle", 64'(chg), 64'd4);

    do_cfg(1, 32'h1, 32'hFFFF_FFFF);
    wait_lock(40, n, tk);
    chk("settle_tick_suppressed", 64'(tk), 64'd0);
    chk("wrap_relock", 64'(n), 64'd16);

    do_cfg(1, 32'h0, 32'h8000_0000);
    wait_lock(40, n, tk);
    tk = 0; chg = 0;
    repeat (8) begin
      step(1);
      tk += int'(tick_out[1]);
      chg += int'(clk_out[1] != 1'b1);
    end
    chk("inc0_no_tick", 64'(tk), 64'd0);
    chk("inc0_clk_high", 64'(chg), 64'd0);

    step(1);
    cfg_valid = 1'b1; cfg_ch = '0; cfg_inc = 32'h4000_0000; cfg_phase = '0;
    #1 rst = 1'b1;
    #1;
    chk("arst_tick", 64'(tick_out), 64'd0);
    chk("arst_clk", 64'(clk_out), 64'd0);
    chk("arst_locked", 64'(locked), 64'd0);
    chk("arst_ready", 64'(cfg_ready), 64'd0);
    chk("arst_err", 64'(cfg_err), 64'd0);
    step(2);
    cfg_valid = 1'b0;
    rst = 1'b0;
    wait_lock(40, n, tk);
    chk("arst_lock_latency", 64'(n), 64'd17);
    ticks = 0;
    repeat (100) begin
      step(1);
      ticks += int'(tick_out[0]);
    end
    chk("arst_cfg_not_applied", 64'(ticks >= 23 && ticks <= 24), 64'd1);

    @(negedge refclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
